// File: rtl/data_memory.sv
// data_memory: word-organised data memory behind the load/store queue.
// One load or store is accepted per request; hits complete at the accept
// edge and misses complete MISS_LATENCY edges later. Only one access is in
// flight at a time, so completions always come out in acceptance order.
//
// Request handshake: a request is "valid" on any rising edge where
// memRead|memWrite is high. There is no ready output: the memory is
// implicitly ready only in IDLE, and a request arriving while a miss is
// outstanding (including on its completion edge) is dropped. The caller
// holds a request for exactly one accepting edge; if it is held longer it is
// accepted again and executes again. memRead&memWrite together is a store.
//
// DEPTH must be a power of two; the word index is address[IDX_W+1:2].
// Note: rstn is active-HIGH despite its name.
module data_memory #(
    parameter int DEPTH        = 256,
    parameter int MISS_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] PC_in,
    input  logic [31:0] address,
    input  logic [31:0] dataSw,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        storeSize,
    input  logic        cacheMiss,
    input  logic        fromLSQ,
    output logic [31:0] lwData,
    output logic [31:0] PC_out,
    output logic        dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int ADR_W = IDX_W + 2;
    localparam int CNT_W = $clog2(MISS_LATENCY + 1);

    typedef enum logic {
        IDLE      = 1'b0,
        MISS_WAIT = 1'b1
    } state_t;

    // Registered state
    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [31:0]        pc_lat_q,   pc_lat_d;
    logic [ADR_W-1:0]   addr_lat_q, addr_lat_d;
    logic [31:0]        data_lat_q, data_lat_d;
    logic               size_lat_q, size_lat_d;
    logic               store_lat_q, store_lat_d;
    logic               lsq_lat_q,  lsq_lat_d;
    logic [31:0]        lw_data_q,  lw_data_d;
    logic [31:0]        pc_out_q,   pc_out_d;
    logic [31:0]        mem_q [DEPTH];

    // Completion datapath, shared by hit and miss completions
    logic               req;
    logic               comp_valid;
    logic               comp_store;
    logic [ADR_W-1:0]   comp_addr;
    logic [31:0]        comp_data;
    logic               comp_size;
    logic               comp_lsq;
    logic [31:0]        comp_pc;
    logic [IDX_W-1:0]   comp_idx;
    logic [31:0]        rd_word;
    logic               wr_en;
    logic [31:0]        wr_data;

    // Address bits above the array are ignored (addresses wrap modulo DEPTH)
    logic               unused_addr_hi;
    assign unused_addr_hi = ^address[31:ADR_W];

    assign req = memRead | memWrite;

    // Next-state logic: accept in IDLE, count down a miss, pick the completing access
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_lat_d    = pc_lat_q;
        addr_lat_d  = addr_lat_q;
        data_lat_d  = data_lat_q;
        size_lat_d  = size_lat_q;
        store_lat_d = store_lat_q;
        lsq_lat_d   = lsq_lat_q;
        comp_valid  = 1'b0;
        comp_store  = 1'b0;
        comp_addr   = '0;
        comp_data   = '0;
        comp_size   = 1'b0;
        comp_lsq    = 1'b0;
        comp_pc     = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (cacheMiss) begin
                        state_d     = MISS_WAIT;
                        cnt_d       = CNT_W'(MISS_LATENCY - 1);
                        pc_lat_d    = PC_in;
                        addr_lat_d  = address[ADR_W-1:0];
                        data_lat_d  = dataSw;
                        size_lat_d  = storeSize;
                        store_lat_d = memWrite;
                        lsq_lat_d   = fromLSQ;
                    end else begin
                        comp_valid = 1'b1;
                        comp_store = memWrite;
                        comp_addr  = address[ADR_W-1:0];
                        comp_data  = dataSw;
                        comp_size  = storeSize;
                        comp_lsq   = fromLSQ;
                        comp_pc    = PC_in;
                    end
                end
            end
            MISS_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    comp_valid = 1'b1;
                    comp_store = store_lat_q;
                    comp_addr  = addr_lat_q;
                    comp_data  = data_lat_q;
                    comp_size  = size_lat_q;
                    comp_lsq   = lsq_lat_q;
                    comp_pc    = pc_lat_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion effect: array read/merge for stores, result word for loads
    always_comb begin
        comp_idx  = comp_addr[ADR_W-1:2];
        rd_word   = mem_q[comp_idx];
        wr_en     = 1'b0;
        wr_data   = rd_word;
        lw_data_d = '0;
        pc_out_d  = '0;
        if (comp_valid) begin
            pc_out_d = comp_pc;
            if (comp_store) begin
                wr_en = 1'b1;
                if (comp_size) begin
                    case (comp_addr[1:0])
                        2'd0:    wr_data[7:0]   = comp_data[7:0];
                        2'd1:    wr_data[15:8]  = comp_data[7:0];
                        2'd2:    wr_data[23:16] = comp_data[7:0];
                        default: wr_data[31:24] = comp_data[7:0];
                    endcase
                end else begin
                    wr_data = comp_data;
                end
            end else begin
                lw_data_d = comp_lsq ? comp_data : rd_word;
            end
        end
    end

    // FSM, latched request and registered outputs
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pc_lat_q    <= '0;
            addr_lat_q  <= '0;
            data_lat_q  <= '0;
            size_lat_q  <= 1'b0;
            store_lat_q <= 1'b0;
            lsq_lat_q   <= 1'b0;
            lw_data_q   <= '0;
            pc_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_lat_q    <= pc_lat_d;
            addr_lat_q  <= addr_lat_d;
            data_lat_q  <= data_lat_d;
            size_lat_q  <= size_lat_d;
            store_lat_q <= store_lat_d;
            lsq_lat_q   <= lsq_lat_d;
            lw_data_q   <= lw_data_d;
            pc_out_q    <= pc_out_d;
        end
    end

    // Storage array; cleared by reset, one word written per completing store
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[comp_idx] <= wr_data;
        end
    end

    assign lwData    = lw_data_q;
    assign PC_out    = pc_out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed scenarios plus randomized traffic for data_memory,
// checked against a word-array reference model through an expected queue.
module tb_data_memory;

  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  logic        clk;
  logic        rstn;
  logic [31:0] PC_in;
  logic [31:0] address;
  logic [31:0] dataSw;
  logic        memRead;
  logic        memWrite;
  logic        storeSize;
  logic        cacheMiss;
  logic        fromLSQ;
  logic [31:0] lwData;
  logic [31:0] PC_out;
  logic        dbg_state;

  data_memory #(.DEPTH(DEPTH), .MISS_LATENCY(LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .PC_in     (PC_in),
    .address   (address),
    .dataSw    (dataSw),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .storeSize (storeSize),
    .cacheMiss (cacheMiss),
    .fromLSQ   (fromLSQ),
    .lwData    (lwData),
    .PC_out    (PC_out),
    .dbg_state (dbg_state)
  );

  // clock / reset / cycle count
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // reference model + scoreboard: {completion cycle, pc, load data}
  logic [95:0] exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          busy_end = 0;
  int          total = 0;
  int          bad   = 0;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    exp_q.delete();
    busy_end = 0;
  endtask

  // Drive one request for one edge; the model decides whether it is accepted.
  // Called at #1 after a rising edge, returns at #1 after the next one.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] pc,
                       input logic sz, input logic miss, input logic lsq);
    int          e;
    int          idx;
    logic [31:0] word;
    logic [31:0] exp_d;
    memRead   = rd;
    memWrite  = wr;
    address   = addr;
    dataSw    = data;
    PC_in     = pc;
    storeSize = sz;
    cacheMiss = miss;
    fromLSQ   = lsq;
    e = cyc + 1;
    if ((rd || wr) && e > busy_end) begin
      idx = int'((addr >> 2) % DEPTH);
      exp_d = 32'h0;
      if (wr) begin
        word = ref_mem[idx];
        if (sz) word[8*addr[1:0] +: 8] = data[7:0];
        else    word = data;
        ref_mem[idx] = word;
      end else begin
        exp_d = lsq ? data : ref_mem[idx];
      end
      busy_end = miss ? e + LAT : e;
      exp_q.push_back({32'(busy_end), pc, exp_d});
    end
    @(posedge clk);
    #1;
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() > 0 || busy_end >= cyc) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 100) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: queue still holds %0d entries, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
  endtask

  // monitor: compare every cycle's outputs against the expected queue
  always @(negedge clk) begin
    logic [95:0] e;
    if (rstn) begin
      total++;
      if (PC_out !== 32'h0 || lwData !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs: PC_out=%h lwData=%h, required 0/0", PC_out, lwData);
      end
    end else if (PC_out !== 32'h0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_completion: cyc=%0d PC_out=%h lwData=%h, none expected",
                 cyc, PC_out, lwData);
      end else begin
        e = exp_q.pop_front();
        if (e[95:64] !== 32'(cyc) || e[63:32] !== PC_out || e[31:0] !== lwData) begin
          bad++;
          $display("FAIL completion: got cyc=%0d pc=%h data=%h, required cyc=%0d pc=%h data=%h",
                   cyc, PC_out, lwData, e[95:64], e[63:32], e[31:0]);
        end
      end
    end else begin
      total++;
      if (lwData !== 32'h0) begin
        bad++;
        $display("FAIL idle_data: cyc=%0d lwData=%h with PC_out=0, required 0", cyc, lwData);
      end
      if (exp_q.size() > 0) begin
        total++;
        if (exp_q[0][95:64] <= 32'(cyc)) begin
          bad++;
          e = exp_q.pop_front();
          $display("FAIL missed_completion: cyc=%0d PC_out=0, required pc=%h data=%h at cyc=%0d",
                   cyc, e[63:32], e[31:0], e[95:64]);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] a;
    logic [31:0] pc;
    int          op;
    rstn = 1'b1;
    {PC_in, address, dataSw} = '0;
    {memRead, memWrite, storeSize, cacheMiss, fromLSQ} = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    idle(1);

    // reset interrupting a miss store: the store must never land
    issue(0, 1, 32'h4, 32'hDEAD_BEEF, 32'h8, 0, 1, 0);
    idle(2);
    do_reset();
    issue(1, 0, 32'h4, 32'h0, 32'h4, 0, 0, 0);      // hit load of cleared word -> 0
    drain();

    // miss store; requests during the wait and on the completion edge are dropped
    issue(0, 1, 32'h4, 32'h23, 32'h10, 0, 1, 0);
    issue(1, 0, 32'h8, 32'h0, 32'h14, 0, 0, 0);
    issue(0, 1, 32'h4, 32'h99, 32'h15, 0, 0, 0);
    idle(1);
    issue(0, 1, 32'h4, 32'h77, 32'h16, 0, 0, 0);
    issue(1, 0, 32'h4, 32'h0, 32'h20, 0, 0, 0);     // first edge after completion -> 0x23
    drain();

    issue(0, 1, 32'h8, 32'h46, 32'h14, 0, 1, 0);
    drain();
    issue(1, 0, 32'h4, 32'h0, 32'h18, 0, 0, 0);     // -> 0x23
    issue(1, 0, 32'h8, 32'h0, 32'h1C, 0, 1, 0);     // miss -> 0x46
    drain();

    // byte merge: 0x11223344 then 0xAA into lane 2 -> 0x11AA3344
    issue(0, 1, 32'h10, 32'h1122_3344, 32'h24, 0, 0, 0);
    issue(0, 1, 32'h12, 32'h0000_00AA, 32'h28, 1, 0, 0);
    issue(1, 0, 32'h10, 32'h0, 32'h2C, 0, 0, 0);
    issue(0, 1, 32'h13, 32'hFFFF_FF5C, 32'h2E, 1, 1, 0);  // miss byte store lane 3
    drain();
    issue(1, 0, 32'h11, 32'h0, 32'h2F, 0, 1, 0);          // low addr bits ignored on loads
    drain();

    // forwarded load does not read or touch the array
    issue(1, 0, 32'h4, 32'h55, 32'h30, 0, 0, 1);
    issue(1, 0, 32'h4, 32'h0, 32'h34, 0, 0, 0);
    // wrap-around and read+write treated as store
    issue(1, 0, 32'h4 + DEPTH * 4, 32'h0, 32'h38, 0, 0, 0);
    issue(1, 1, 32'h40, 32'h77, 32'h3C, 0, 0, 0);
    issue(1, 0, 32'h40 + 3 * DEPTH * 4, 32'h0, 32'h3E, 0, 1, 0);
    drain();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        drain();
        do_reset();
      end
      op = $urandom_range(0, 4);
      a  = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = a + DEPTH * 4 * $urandom_range(1, 7);
      pc = $urandom_range(1, 65535) << 2;
      issue(op == 0 || op == 3, op == 1 || op == 2 || op == 3, a, $urandom, pc,
            1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
    end
    drain();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
